// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-type encodings and their field width.
package cpu_pkg;

   localparam int LD_TYPE_W = 3;

   typedef enum logic [LD_TYPE_W-1:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LBU  = 3'd2,
      LD_LH   = 3'd3,
      LD_LHU  = 3'd4,
      LD_LW   = 3'd5,
      LD_LWL  = 3'd6,
      LD_LWR  = 3'd7
   } ld_type_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction and LWL/LWR merge (purely combinational).
// Build option: WB_LWLR_EN enables LWL/LWR merging; without it both act as LW.
module load_align
   import cpu_pkg::*;
(
   input  ld_type_t    ld_type,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   input  logic [31:0] rt_old,
   input  logic [31:0] alu_result,
   output logic [31:0] result
);

   logic [7:0]  byte_lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Split the read word into its four byte lanes.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = rdata[8*gi +: 8];
      end
   endgenerate

   // Pick the addressed byte and halfword.
   always_comb begin
      byte_sel = byte_lane[addr];
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
   end

`ifdef WB_LWLR_EN
   logic [31:0] lwl_data;
   logic [31:0] lwr_data;

   // Little-endian unaligned-word merges with the old rt value.
   always_comb begin
      case (addr)
         2'd0:    lwl_data = {rdata[7:0],  rt_old[23:0]};
         2'd1:    lwl_data = {rdata[15:0], rt_old[15:0]};
         2'd2:    lwl_data = {rdata[23:0], rt_old[7:0]};
         default: lwl_data = rdata;
      endcase
      case (addr)
         2'd0:    lwr_data = rdata;
         2'd1:    lwr_data = {rt_old[31:24], rdata[31:8]};
         2'd2:    lwr_data = {rt_old[31:16], rdata[31:16]};
         default: lwr_data = {rt_old[31:8],  rdata[31:24]};
      endcase
   end
`else
   // Without the merge feature the old rt value has no consumer.
   logic unused_rt_old;
   assign unused_rt_old = ^rt_old;
`endif

   // Final result select by load type.
   always_comb begin
      result = alu_result;
      case (ld_type)
         LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  result = {24'd0, byte_sel};
         LD_LH:   result = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  result = {16'd0, half_sel};
         LD_LW:   result = rdata;
`ifdef WB_LWLR_EN
         LD_LWL:  result = lwl_data;
         LD_LWR:  result = lwr_data;
`else
         LD_LWL:  result = rdata;
         LD_LWR:  result = rdata;
`endif
         default: result = alu_result;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Pipeline writeback stage: holds one instruction, aligns load data,
// drives the register-file write port and counts retired instructions.
// Build option: WB_LWLR_EN (LWL/LWR merging inside load_align).
module writeback_stage
   import cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ms_to_ws_valid,
   output logic                 ws_allowin,
   input  logic [31:0]          ms_pc,
   input  logic [31:0]          ms_alu_result,
   input  logic [4:0]           ms_dest,
   input  logic [2:0]           ms_ld_type,
   input  logic [31:0]          ms_rt_old,
   input  logic [31:0]          data_sram_rdata,
   input  logic                 wb_stall,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic [CNT_W-1:0]     retire_cnt,
   output logic [31:0]          debug_wb_pc
);

   logic              ws_valid_reg;
   logic              first_reg;
   logic [31:0]       rdata_buf_reg;
   logic [31:0]       pc_reg;
   logic [31:0]       alu_result_reg;
   logic [4:0]        dest_reg;
   logic [2:0]        ld_type_reg;
   logic [31:0]       rt_old_reg;
   logic [CNT_W-1:0]  retire_cnt_reg;

   logic              ws_ready_go;
   logic              capture;
   logic              retire;
   logic [31:0]       eff_rdata;
   logic [31:0]       load_result;

   assign ws_ready_go = ~wb_stall;
   assign ws_allowin  = ~ws_valid_reg | ws_ready_go;
   assign capture     = ms_to_ws_valid & ws_allowin;
   assign retire      = ws_valid_reg & ws_ready_go;

   // Valid bit follows the upstream valid whenever a slot is offered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid_reg <= 1'b0;
      end else if (ws_allowin) begin
         ws_valid_reg <= ms_to_ws_valid;
      end
   end

   // Payload latch; first_reg marks the one cycle the SRAM data is live.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         first_reg      <= 1'b0;
         pc_reg         <= 32'd0;
         alu_result_reg <= 32'd0;
         dest_reg       <= 5'd0;
         ld_type_reg    <= 3'd0;
         rt_old_reg     <= 32'd0;
      end else begin
         first_reg <= capture;
         if (capture) begin
            pc_reg         <= ms_pc;
            alu_result_reg <= ms_alu_result;
            dest_reg       <= ms_dest;
            ld_type_reg    <= ms_ld_type;
            rt_old_reg     <= ms_rt_old;
         end
      end
   end

   // Keep a copy of the SRAM word so a long stall still sees stable data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_buf_reg <= 32'd0;
      end else if (first_reg) begin
         rdata_buf_reg <= data_sram_rdata;
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         retire_cnt_reg <= '0;
      end else if (retire) begin
         retire_cnt_reg <= retire_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign eff_rdata = first_reg ? data_sram_rdata : rdata_buf_reg;

   load_align u_load_align (
      .ld_type    (ld_type_t'(ld_type_reg)),
      .addr       (alu_result_reg[1:0]),
      .rdata      (eff_rdata),
      .rt_old     (rt_old_reg),
      .alu_result (alu_result_reg),
      .result     (load_result)
   );

   // Register-file port and debug PC, zeroed when no instruction is held.
   always_comb begin
      rf_we       = retire & (dest_reg != 5'd0);
      rf_waddr    = 5'd0;
      rf_wdata    = 32'd0;
      debug_wb_pc = 32'd0;
      if (ws_valid_reg) begin
         rf_waddr    = dest_reg;
         rf_wdata    = load_result;
         debug_wb_pc = pc_reg;
      end
   end

   assign retire_cnt = retire_cnt_reg;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
- REQ-001 SHALL provide parameter CNT_W, default 32: width of the retired-instruction counter.
- REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003 SHALL provide port resetn  input  1  reset, asynchronous assertion, active-low.
- REQ-004 SHALL provide port ms_to_ws_valid  input  1  memory stage presents a valid instruction.
- REQ-005 SHALL provide port ws_allowin  output  1  writeback can accept an instruction this cycle.
- REQ-006 SHALL provide port ms_pc  input  32  instruction PC.
- REQ-007 SHALL provide port ms_alu_result  input  32  ALU result; also the load byte address.
- REQ-008 SHALL provide port ms_dest  input  5  destination register; 0 means no write.
- REQ-009 SHALL provide port ms_ld_type  input  3  load type: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
- REQ-010 SHALL provide port ms_rt_old  input  32  old rt value for LWL/LWR merge.
- REQ-011 SHALL provide port data_sram_rdata  input  32  SRAM read data, valid only in the first cycle the load occupies writeback.
- REQ-012 SHALL provide port wb_stall  input  1  external hold request for writeback.
- REQ-013 SHALL provide port rf_we  output  1  register-file write enable; also the forwarding valid.
- REQ-014 SHALL provide port rf_waddr  output  5  register-file write address.
- REQ-015 SHALL provide port rf_wdata  output  32  register-file write data.
- REQ-016 SHALL provide port retire_cnt  output  CNT_W  retired-instruction count.
- REQ-017 SHALL provide port debug_wb_pc  output  32  PC of the instruction held in writeback.

Function
- REQ-018 SHALL hold an internal ws_valid bit, with ws_ready_go = !wb_stall and ws_allowin = !ws_valid | ws_ready_go.
- REQ-019 SHALL load ws_valid with ms_to_ws_valid on every edge where ws_allowin=1, and SHALL latch the payload (pc, alu_result, dest, ld_type, rt_old) only when ms_to_ws_valid & ws_allowin.
- REQ-020 SHALL set a first-cycle flag on payload capture and clear it on the next edge.
- REQ-021 SHALL capture data_sram_rdata into rdata_buf while the first-cycle flag is set.
- REQ-022 SHALL use data_sram_rdata as effective read data in the first cycle and rdata_buf afterwards, so stalls of any length return stable data.
- REQ-023 SHALL extract load data using ld_type and addr[1:0]:
  - LB/LBU: select byte addr[1:0], sign- or zero-extend.
  - LH/LHU: select halfword addr[1], sign- or zero-extend.
  - LW: the whole word; addr[1:0] is ignored.
  - NONE: alu_result.
- REQ-024 SHALL merge LWL (little-endian) as follows:
  - a=0: {rd[7:0],rt[23:0]}
  - a=1: {rd[15:0],rt[15:0]}
  - a=2: {rd[23:0],rt[7:0]}
  - a=3: rd
- REQ-025 SHALL merge LWR as follows:
  - a=0: rd
  - a=1: {rt[31:24],rd[31:8]}
  - a=2: {rt[31:16],rd[31:16]}
  - a=3: {rt[31:8],rd[31:24]}
- REQ-026 SHALL drive rf_we = ws_valid & ws_ready_go & (dest!=0), combinationally, for exactly the cycle the instruction retires.
- REQ-027 SHALL increment retire_cnt by one per retiring valid instruction regardless of dest, wrapping modulo 2^CNT_W.
- REQ-028 SHALL drive rf_waddr, rf_wdata and debug_wb_pc from the held payload whenever ws_valid=1, and drive them to 0 otherwise.

Reset
- REQ-029 SHALL, while resetn=0, force ws_valid, the first-cycle flag, rdata_buf, all payload registers and retire_cnt to 0, and hence drive rf_we=0.
- REQ-030 SHALL drop an instruction caught mid-stall when reset asserts; it SHALL NOT be written.

Configuration
- REQ-031 SHALL implement LWL/LWR merging per REQ-024 and REQ-025 when WB_LWLR_EN is defined.
- REQ-032 SHALL, without WB_LWLR_EN, treat ld_type 6/7 as LW and leave ms_rt_old unused.

Structure
- REQ-033 SHALL place the load-type encodings and their width in shared package cpu_pkg.
- REQ-034 SHALL implement extraction and merge as combinational sub-module load_align (inputs: ld_type, addr[1:0], rdata, rt_old, alu_result).

Verification
- REQ-035 SHALL verify LB: addr 0x1003, rdata 0x80FF_1234 -> rf_wdata 0xFFFF_FF80; with LBU -> 0x0000_0080.
- REQ-036 SHALL verify LH stalled 3 cycles: addr 0x2002, rdata 0x8001_5555 in the first cycle then 0xDEAD_BEEF -> a single rf_we pulse on release with data 0xFFFF_8001.
- REQ-037 SHALL verify LWL: addr a=1, rdata 0xAABB_CCDD, rt 0x1122_3344 -> 0xCCDD_3344; LWR a=2 -> 0x1122_AABB; without macro both -> 0xAABB_CCDD.
- REQ-038 SHALL verify back-to-back ALU instructions with dest 5, 0, 7 -> two rf_we pulses, retire_cnt +3; with CNT_W=4 from 0xF it wraps to 0x2.
- REQ-039 SHALL verify resetn dropped while stalled with valid dest 9 -> no rf_we, retire_cnt 0; after release, first accept works.
